// File: rtl/sd_wb_dma_master.sv
// sd_wb_dma_master: Wishbone master moving runs of 32-bit words between memory and the SD data FIFOs.
module sd_wb_dma_master #(
    parameter int BLKSIZE_W = 12,
    parameter int BLKCNT_W  = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_tx_i,
    input  logic                 start_rx_i,
    input  logic                 abort_i,
    input  logic [31:0]          dma_addr_i,
    input  logic [BLKSIZE_W-1:0] block_size_i,
    input  logic [BLKCNT_W-1:0]  block_count_i,
    output logic [31:0]          m_wb_adr_o,
    output logic [31:0]          m_wb_dat_o,
    input  logic [31:0]          m_wb_dat_i,
    output logic [3:0]           m_wb_sel_o,
    output logic                 m_wb_we_o,
    output logic                 m_wb_cyc_o,
    output logic                 m_wb_stb_o,
    input  logic                 m_wb_ack_i,
    input  logic                 m_wb_err_i,
    output logic [31:0]          tx_fifo_wdata_o,
    output logic                 tx_fifo_wr_o,
    input  logic                 tx_fifo_full_i,
    input  logic [31:0]          rx_fifo_rdata_i,
    output logic                 rx_fifo_rd_o,
    input  logic                 rx_fifo_empty_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int WC_W = BLKSIZE_W - 1;

    typedef enum logic [3:0] {IDLE, TX_WAIT, TX_BUS, TX_PUSH, RX_WAIT, RX_POP, RX_LOAD, RX_BUS, DONE} state_t;

    state_t              state, state_n;
    logic [WC_W-1:0]     wpb, wcnt, wpb_in;
    logic [BLKCNT_W-1:0] bcnt;
    logic                adv, bus_err, last, bus_n, unused_ok;

    assign wpb_in    = WC_W'(block_size_i[BLKSIZE_W-1:2]) + WC_W'(1);
    assign last      = (wcnt == WC_W'(1)) && (bcnt == '0);
    assign bus_n     = (state_n == TX_BUS) || (state_n == RX_BUS);
    assign unused_ok = ^{dma_addr_i[1:0], block_size_i[1:0]};

    always_comb begin
        state_n = state;
        adv     = 1'b0;
        bus_err = 1'b0;
        case (state)
            IDLE:    state_n = start_tx_i ? TX_WAIT : start_rx_i ? RX_WAIT : IDLE;
            TX_WAIT: state_n = tx_fifo_full_i ? TX_WAIT : TX_BUS;
            TX_BUS: begin
                bus_err = m_wb_err_i;
                state_n = m_wb_err_i ? IDLE : m_wb_ack_i ? TX_PUSH : TX_BUS;
            end
            TX_PUSH: begin
                adv     = 1'b1;
                state_n = last ? DONE : TX_WAIT;
            end
            RX_WAIT: state_n = rx_fifo_empty_i ? RX_WAIT : RX_POP;
            RX_POP:  state_n = RX_LOAD;
            RX_LOAD: state_n = RX_BUS;
            RX_BUS: begin
                bus_err = m_wb_err_i;
                adv     = m_wb_ack_i && !m_wb_err_i;
                state_n = m_wb_err_i ? IDLE : !m_wb_ack_i ? RX_BUS : last ? DONE : RX_WAIT;
            end
            default: state_n = IDLE;
        endcase
        // abort overrides everything, including a simultaneous ack or err
        if (abort_i && state != IDLE) begin
            state_n = IDLE;
            adv     = 1'b0;
            bus_err = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state           <= IDLE;
            wpb             <= '0;
            wcnt            <= '0;
            bcnt            <= '0;
            m_wb_adr_o      <= '0;
            m_wb_dat_o      <= '0;
            m_wb_sel_o      <= '0;
            m_wb_we_o       <= 1'b0;
            m_wb_cyc_o      <= 1'b0;
            m_wb_stb_o      <= 1'b0;
            tx_fifo_wdata_o <= '0;
            tx_fifo_wr_o    <= 1'b0;
            rx_fifo_rd_o    <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            state        <= state_n;
            busy_o       <= state_n != IDLE;
            done_o       <= state_n == DONE;
            err_o        <= bus_err;
            m_wb_cyc_o   <= bus_n;
            m_wb_stb_o   <= bus_n;
            m_wb_we_o    <= state_n == RX_BUS;
            m_wb_sel_o   <= {4{bus_n}};
            tx_fifo_wr_o <= state_n == TX_PUSH;
            rx_fifo_rd_o <= state_n == RX_POP;
            if (state == TX_BUS && state_n == TX_PUSH)
                tx_fifo_wdata_o <= m_wb_dat_i;
            if (state == RX_LOAD && state_n == RX_BUS)
                m_wb_dat_o <= rx_fifo_rdata_i;
            if (state == IDLE && state_n != IDLE) begin
                m_wb_adr_o <= {dma_addr_i[31:2], 2'b00};
                wpb        <= wpb_in;
                wcnt       <= wpb_in;
                bcnt       <= block_count_i;
            end else if (adv) begin
                m_wb_adr_o <= m_wb_adr_o + 32'd4;
                wcnt       <= (wcnt == WC_W'(1)) ? wpb : wcnt - WC_W'(1);
                if (wcnt == WC_W'(1) && bcnt != '0)
                    bcnt <= bcnt - BLKCNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sd_wb_dma_master.sv
// tb_sd_wb_dma_master: randomized bench with a Wishbone slave, FIFO models and an arithmetic reference.
module tb_sd_wb_dma_master;
    logic        clk = 0, rst_n = 0;
    logic        start_tx = 0, start_rx = 0, abort = 0;
    logic [31:0] dma_addr = 0;
    logic [11:0] bsize = 0;
    logic [15:0] bcnt = 0;
    logic [31:0] adr, dat_o, dat_i = 0;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack = 0, err = 0;
    logic [31:0] tx_wdata, rx_rdata = 0;
    logic        tx_wr, tx_full = 0, rx_rd, rx_empty = 1;
    logic        busy, done, err_p;

    sd_wb_dma_master #(.BLKSIZE_W(12), .BLKCNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start_tx_i(start_tx), .start_rx_i(start_rx),
        .abort_i(abort), .dma_addr_i(dma_addr), .block_size_i(bsize), .block_count_i(bcnt),
        .m_wb_adr_o(adr), .m_wb_dat_o(dat_o), .m_wb_dat_i(dat_i), .m_wb_sel_o(sel),
        .m_wb_we_o(we), .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_ack_i(ack), .m_wb_err_i(err),
        .tx_fifo_wdata_o(tx_wdata), .tx_fifo_wr_o(tx_wr), .tx_fifo_full_i(tx_full),
        .rx_fifo_rdata_i(rx_rdata), .rx_fifo_rd_o(rx_rd), .rx_fifo_empty_i(rx_empty),
        .busy_o(busy), .done_o(done), .err_o(err_p)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] rd_adr_q[$], wr_adr_q[$], wr_dat_q[$], push_q[$], rx_q[$];
    logic [31:0] key = 0;
    int ws = 0, err_at = 1000, bus_n = 0, s_wait = 0;
    int full_after = 0, full_hold = 0, full_cnt = 0, rx_gap = 0, gate_cnt = 0;
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int full_viol = 0, empty_viol = 0, stay_viol = 0, sel_viol = 0;

    // slave, FIFO models and protocol monitors, all evaluated between active edges
    always @(negedge clk) begin
        if ((ack || err) && cyc) stay_viol++;
        if (tx_full && cyc) full_viol++;
        if (rx_rd && rx_empty) empty_viol++;
        done_cnt += int'(done);
        err_cnt  += int'(err_p);
        busy_cnt += int'(busy);
        ack = 0;
        err = 0;
        if (cyc && stb) begin
            if (s_wait >= ws) begin
                s_wait = 0;
                if (sel != 4'hF) sel_viol++;
                if (bus_n == err_at) err = 1;
                else begin
                    ack = 1;
                    if (we) begin
                        wr_adr_q.push_back(adr);
                        wr_dat_q.push_back(dat_o);
                    end else begin
                        rd_adr_q.push_back(adr);
                        dat_i = adr ^ key;
                    end
                end
                bus_n++;
            end else s_wait++;
        end else s_wait = 0;
        if (tx_wr) begin
            push_q.push_back(tx_wdata);
            if (push_q.size() == full_after) full_cnt = full_hold;
        end else if (full_cnt > 0) full_cnt--;
        tx_full = full_cnt > 0;
        if (rx_rd) begin
            if (rx_q.size() > 0) rx_rdata = rx_q.pop_front();
            else empty_viol++;
            gate_cnt = rx_gap;
        end else if (gate_cnt > 0) gate_cnt--;
        rx_empty = (rx_q.size() == 0) || (gate_cnt > 0);
    end

    task automatic setup(input int ws_i, input int fa, input int fh, input int gap, input int ea, input logic [31:0] k);
        @(posedge clk);
        rd_adr_q.delete(); wr_adr_q.delete(); wr_dat_q.delete(); push_q.delete(); rx_q.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; bus_n = 0;
        full_viol = 0; empty_viol = 0; stay_viol = 0; sel_viol = 0;
        ws = ws_i; full_after = fa; full_hold = fh; full_cnt = 0; rx_gap = gap; gate_cnt = 0;
        err_at = ea; key = k;
    endtask

    task automatic run(input bit tx, input bit both, input logic [31:0] a, input logic [11:0] bs,
                       input logic [15:0] bc, input int ws_i, input int fa, input int fh, input int gap,
                       input int ea, input logic [31:0] k, input int exp_busy);
        int words, total, n, t;
        logic [31:0] base, e;
        words = int'(bs[11:2]) + 1;
        total = (int'(bc) + 1) * words;
        base  = {a[31:2], 2'b00};
        n     = (ea < total) ? ea : total;
        setup(ws_i, fa, fh, gap, ea, k);
        if (!tx) for (int i = 0; i < total; i++) rx_q.push_back(k + 32'(i));
        @(negedge clk);
        dma_addr = a; bsize = bs; bcnt = bc;
        start_tx = tx | both;
        start_rx = !tx | both;
        @(posedge clk); #1;
        start_tx = 0; start_rx = 0;
        check("busy_after_start", busy, 1);
        t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check("finished", t < 4000, 1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_end", busy, 0);
        check("done_cnt", done_cnt, (ea < total) ? 0 : 1);
        check("err_cnt", err_cnt, (ea < total) ? 1 : 0);
        check("full_viol", full_viol, 0);
        check("empty_viol", empty_viol, 0);
        check("stay_viol", stay_viol, 0);
        check("sel_viol", sel_viol, 0);
        if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
        if (tx) begin
            check("rd_count", rd_adr_q.size(), n);
            check("push_count", push_q.size(), n);
            check("tx_no_writes", wr_adr_q.size(), 0);
            for (int i = 0; i < n && i < rd_adr_q.size() && i < push_q.size(); i++) begin
                e = base + 32'(4 * i);
                check("rd_adr", rd_adr_q[i], e);
                check("push_dat", push_q[i], e ^ k);
            end
        end else begin
            check("wr_count", wr_adr_q.size(), n);
            check("rx_no_reads", rd_adr_q.size(), 0);
            check("rx_no_push", push_q.size(), 0);
            for (int i = 0; i < n && i < wr_adr_q.size(); i++) begin
                check("wr_adr", wr_adr_q[i], base + 32'(4 * i));
                check("wr_dat", wr_dat_q[i], k + 32'(i));
            end
        end
    endtask

    task automatic start_and_wait_cyc(input logic [31:0] a);
        int t;
        setup(40, 0, 0, 0, 1000, 0);
        @(negedge clk);
        dma_addr = a; bsize = 12'd15; bcnt = 16'd0; start_tx = 1;
        @(posedge clk); #1;
        start_tx = 0;
        t = 0;
        while (!cyc && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("saw_cyc", cyc, 1);
    endtask

    initial begin
        int ea;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {cyc, stb, we, tx_wr, rx_rd, busy, done, err_p, sel}, 0);
        check("rst_adr", adr, 0);
        check("rst_data", {dat_o, tx_wdata}, 0);
        @(negedge clk) rst_n = 1;

        run(1, 0, 32'h1000, 12'd15, 16'd0, 0, 0, 0, 0, 1000, 32'h0, 13);
        run(0, 0, 32'h2000, 12'd7, 16'd1, 0, 0, 0, 3, 1000, 32'hA0, -1);
        run(1, 0, 32'h4000, 12'd15, 16'd0, 2, 2, 5, 0, 1000, 32'h5A5A0000, -1);
        run(0, 0, 32'h5000, 12'd15, 16'd0, 0, 0, 0, 0, 1, 32'h77, -1);
        run(0, 0, 32'h5000, 12'd15, 16'd0, 0, 0, 0, 0, 1000, 32'h88, -1);

        start_and_wait_cyc(32'h3000);
        @(negedge clk) abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_bus", {cyc, stb, we}, 0);
        check("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_no_err", err_cnt, 0);
        check("abort_no_push", push_q.size(), 0);

        run(1, 0, 32'hFFFFFFF8, 12'd15, 16'd0, 0, 0, 0, 0, 1000, 32'h0, 13);
        run(1, 1, 32'h6003, 12'd15, 16'd0, 1, 0, 0, 0, 1000, 32'h1234, -1);

        for (int r = 0; r < 24; r++) begin
            ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 1000;
            run(1'($urandom_range(0, 1)), 0, $urandom, 12'($urandom_range(0, 31)), 16'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)), ea, $urandom, -1);
        end

        start_and_wait_cyc(32'h7000);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_rst_ctrl", {cyc, stb, we, tx_wr, rx_rd, busy, done, err_p}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_adr", adr, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_wb_dma_master.md
# sd_wb_dma_master

Wishbone bus initiator for the SD card controller's block data path. It moves a programmed run of 32-bit words between system memory and the controller's data FIFOs. Memory-to-card (TX) transfers read memory and push into the TX FIFO; card-to-memory (RX) transfers pop the RX FIFO and write memory. It is the bus-master counterpart of the controller's Wishbone register slave and takes its address, block size and block count from that slave's register outputs.

## Interface
- BLKSIZE_W, 12, width of block_size_i.
- BLKCNT_W, 16, width of block_count_i.
- wb_clk_i  in  1  bus clock; single clock domain.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- start_tx_i / start_rx_i  in  1  one-cycle start pulses, sampled only in IDLE.
- abort_i  in  1  cancels any transfer.
- dma_addr_i  in  32  start byte address; bits [1:0] ignored.
- block_size_i  in  BLKSIZE_W  bytes per block minus 1; words per block = block_size_i[BLKSIZE_W-1:2]+1.
- block_count_i  in  BLKCNT_W  blocks minus 1.
- m_wb_adr_o  out  32; m_wb_dat_o  out  32; m_wb_dat_i  in  32; m_wb_sel_o  out  4; m_wb_we_o, m_wb_cyc_o, m_wb_stb_o  out  1; m_wb_ack_i, m_wb_err_i  in  1: classic Wishbone master port.
- tx_fifo_wdata_o  out  32; tx_fifo_wr_o  out  1; tx_fifo_full_i  in  1.
- rx_fifo_rdata_i  in  32 (valid the cycle after rx_fifo_rd_o); rx_fifo_rd_o  out  1; rx_fifo_empty_i  in  1.
- busy_o  out  1  state != IDLE.
- done_o / err_o  out  1  one-cycle completion / bus-error pulses.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- IDLE: on start_tx_i, latch address = {dma_addr_i[31:2],2'b00}, word counter = words per block, and block counter = block_count_i, then go to TX_WAIT. On start_rx_i, latch the same values and go to RX_WAIT. If both starts are high, TX wins. Starts outside IDLE are ignored.
- TX_WAIT: stay while tx_fifo_full_i=1. Otherwise go to TX_BUS.
- TX_BUS: cyc=stb=1, we=0, sel=4'hF, adr=current address.
  - On ack: capture m_wb_dat_i into tx_fifo_wdata_o, drop cyc/stb at that edge, go to TX_PUSH.
- TX_PUSH: tx_fifo_wr_o=1 for exactly this cycle. Then advance, going to TX_WAIT or DONE.
- RX_WAIT: stay while rx_fifo_empty_i=1. Otherwise go to RX_POP.
- RX_POP: rx_fifo_rd_o=1 for one cycle, then RX_LOAD.
- RX_LOAD: capture rx_fifo_rdata_i into m_wb_dat_o, then RX_BUS.
- RX_BUS: cyc=stb=we=1, sel=4'hF. On ack: drop cyc/stb/we, advance, go to RX_WAIT or DONE.
- Advance: address += 4 (wraps modulo 2^32), word counter -= 1.
  - When the word counter reaches 0 and the block counter is nonzero: reload the word counter, block counter -= 1.
  - When the word counter reaches 0 and the block counter is 0: DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- m_wb_err_i in a BUS state: cyc/stb/we drop at that edge, err_o=1 for one cycle, go to IDLE. No FIFO write, no done_o.
- abort_i in any non-IDLE state: IDLE at the next edge, cyc/stb/we/fifo strobes 0. No done_o or err_o. An ack coming with the abort is discarded.
- ack and err together: err takes priority.
- Total words = (block_count_i+1)*(words per block). Counters are sized so that block_count_i all-ones is legal.

## Timing
- Start pulse at edge E: busy_o=1 and the WAIT state begin at E+1.
- TX, zero-wait slave, FIFO never full: 3 cycles per word.
  - Sequence is WAIT, BUS, PUSH.
  - tx_fifo_wr_o comes 1 cycle after the ack cycle.
- RX, zero-wait slave, FIFO never empty: 4 cycles per word (WAIT, POP, LOAD, BUS).
- cyc/stb never stay high for the cycle following the ack cycle.
- tx_fifo_full_i / rx_fifo_empty_i reflect a FIFO access one cycle after it. The PUSH state and the WAIT re-check guarantee no overflow or underflow.
- done_o comes 1 cycle after the final PUSH (TX) or the final ack (RX). busy_o falls the cycle after done_o.

## Test plan
- Reset: assert wb_rst_i=0 mid-TX_BUS -> cyc/stb/we/wr/rd/busy/done/err all 0 immediately (async). After release, idle with m_wb_adr_o=0.
- TX: addr 0x1000, block_size 15, block_count 0, zero-wait slave returning data=adr -> 4 reads at 0x1000,0x1004,0x1008,0x100C. FIFO receives 0x1000..0x100C in order, single done_o, busy 13 cycles.
- RX: addr 0x2000, block_size 7, block_count 1, RX FIFO holding 0xA0..0xA3 with empty toggled 3 cycles between words -> writes 0xA0..0xA3 to 0x2000..0x200C with sel=F. No rd_o while empty. Word counter reloads once.
- TX with tx_fifo_full_i held for 5 cycles after word 2 -> no cyc during full. 4 words pushed exactly once each. Slave with 2 wait states -> stb held until ack.
- m_wb_err_i on word 2 of RX -> err_o single pulse, cyc 0 next cycle, no done_o, busy 0. A following start_rx_i restarts from dma_addr_i.
- abort_i during TX_BUS -> IDLE next cycle, no wr/done. Start at 0xFFFFFFF8 with 4 words -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4. start_tx_i and start_rx_i together -> TX executes.
